// File: rtl/score_bcd_ctrl.sv
// score_bcd_ctrl: serial double-dabble converter from a clamped binary score to 2-digit packed BCD
module score_bcd_ctrl #(
    parameter logic [7:0] SAT_VAL = 8'd99
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       req,
    input  logic [7:0] bin,
    output logic       busy,
    output logic       done,
    output logic [7:0] bcd,
    output logic       ovf
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CONV = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [19:0] shift_q, shift_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        clamp_q, clamp_d;
    logic [7:0]  bcd_q, bcd_d;
    logic        ovf_q, ovf_d;
    logic        done_q, done_d;
    logic [19:0] adj;

    function automatic logic [3:0] dab(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Add-3 correction on the three BCD nibbles before each shift
    always_comb begin
        adj = {dab(shift_q[19:16]), dab(shift_q[15:12]), dab(shift_q[11:8]), shift_q[7:0]};
    end

    // Capture in IDLE, one correct-and-shift per CONV cycle; outputs only move on the last one
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        clamp_d = clamp_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (req) begin
                shift_d = {12'b0, (bin > SAT_VAL) ? SAT_VAL : bin};
                clamp_d = bin > SAT_VAL;
                cnt_d   = 3'd0;
                state_d = CONV;
            end
        end else begin
            shift_d = {adj[18:0], 1'b0};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                bcd_d   = shift_d[15:8];
                ovf_d   = clamp_q;
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    // State registers; reset aborts any conversion in flight
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            shift_q <= 20'd0;
            cnt_q   <= 3'd0;
            clamp_q <= 1'b0;
            bcd_q   <= 8'h00;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            clamp_q <= clamp_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == CONV);
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_score_bcd_ctrl.sv
// tb_score_bcd_ctrl: directed scoreboard bench for score_bcd_ctrl
module tb_score_bcd_ctrl;
    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       req = 1'b0;
    logic [7:0] bin = 8'd0;
    logic       busy, done, ovf;
    logic [7:0] bcd;

    int         tests = 0;
    int         fails = 0;
    int         dones = 0;
    int         d0;
    logic [8:0] exp_q[$];
    logic [8:0] e;
    logic [7:0] shown = 8'h00;
    logic       done_d = 1'b0;

    always #5 clk = ~clk;

    score_bcd_ctrl dut (
        .clk(clk), .n_rst(n_rst), .req(req), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .ovf(ovf)
    );

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse pops the next expected {bcd,ovf}
    always @(negedge clk) begin
        if (done) begin
            dones++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got bcd=%h ovf=%b expected no done at %0t", bcd, ovf, $time);
            end else begin
                e = exp_q.pop_front();
                check("result", {bcd, ovf}, e);
            end
            check("done_width", {8'b0, done_d}, 9'd0);
        end
        done_d <= done;
    end

    task automatic convert(input logic [7:0] v, input logic [7:0] eb, input logic eo);
        exp_q.push_back({eb, eo});
        @(negedge clk);
        bin = v;
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        bin = ~v;
        for (int i = 0; i < 8; i++) begin
            check("busy_conv", {8'b0, busy}, 9'd1);
            check("bcd_hold", {1'b0, bcd}, {1'b0, shown});
            check("done_low", {8'b0, done}, 9'd0);
            @(posedge clk);
            #1;
        end
        check("busy_end", {8'b0, busy}, 9'd0);
        check("done_pulse", {8'b0, done}, 9'd1);
        check("bcd_end", {1'b0, bcd}, {1'b0, eb});
        check("ovf_end", {8'b0, ovf}, {8'b0, eo});
        shown = eb;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        check("rst_busy", {8'b0, busy}, 9'd0);
        check("rst_bcd", {1'b0, bcd}, 9'h000);
        n_rst = 1'b1;
        convert(8'd57, 8'h57, 1'b0);
        // Asynchronous reset between edges with a nonzero result shown
        @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        check("arst_busy", {8'b0, busy}, 9'd0);
        check("arst_done", {8'b0, done}, 9'd0);
        check("arst_bcd", {1'b0, bcd}, 9'h000);
        check("arst_ovf", {8'b0, ovf}, 9'd0);
        shown = 8'h00;
        @(posedge clk);
        #2;
        n_rst = 1'b1;
        convert(8'd99, 8'h99, 1'b0);
        convert(8'd0, 8'h00, 1'b0);
        convert(8'd100, 8'h99, 1'b1);
        convert(8'd255, 8'h99, 1'b1);
        convert(8'd1, 8'h01, 1'b0);
        // Requests at E3 and E8 are ignored while converting 42
        exp_q.push_back({8'h42, 1'b0});
        @(negedge clk);
        bin = 8'd42;
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 3 || i == 8) begin
                req = 1'b1;
                bin = 8'd13;
            end
            @(posedge clk);
            #1;
            req = 1'b0;
            check("rej_busy", {8'b0, busy}, (i < 8) ? 9'd1 : 9'd0);
        end
        check("rej_bcd", {1'b0, bcd}, 9'h042);
        shown = 8'h42;
        convert(8'd13, 8'h13, 1'b0);
        convert(8'd42, 8'h42, 1'b0);
        convert(8'd7, 8'h07, 1'b0);
        // Mid-conversion reset aborts 88
        @(negedge clk);
        bin = 8'd88;
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        check("mrst_busy", {8'b0, busy}, 9'd0);
        check("mrst_bcd", {1'b0, bcd}, 9'h000);
        check("mrst_ovf", {8'b0, ovf}, 9'd0);
        shown = 8'h00;
        @(negedge clk);
        n_rst = 1'b1;
        d0 = dones;
        repeat (20) @(posedge clk);
        #1;
        check("no_done_after_abort", dones[8:0], d0[8:0]);
        check("idle_after_abort", {8'b0, busy}, 9'd0);
        convert(8'd64, 8'h64, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("queue_empty", exp_q.size(), 9'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
